calc_result_display: RTL and testbench

//  Downstream display stage for the simple calculator. Captures a 16-bit result and
//  its overflow Flag on a Load pulse. Converts the value to 5 BCD digits with an iterative

---
 rtl/calc_result_display.sv | 169 ++++++++++++++++
 tb/tb_calc_result_display.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_result_display.sv
`default_nettype none
// ============================================================================
//  Module      : calc_result_display
//  Description : Display stage for the calculator. Captures a 16-bit result
//                and overflow flag, converts the value to five BCD digits with
//                an iterative double-dabble engine (16 steps), and drives an
//                8-digit multiplexed active-low seven-segment display with
//                leading-zero blanking and an 'F' overflow indicator.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_result_display #(
  parameter int SCAN_BITS = 18
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Value,
  input  logic        Flag,
  input  logic        Load,
  output logic        Busy,
  output logic [19:0] BcdOut,
  output logic [7:0]  An,
  output logic [6:0]  Ssd,
  output logic        Dp
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CONVERT = 1'b1;

  localparam logic [6:0] c_SEG_BLANK = 7'h7F;
  localparam logic [6:0] c_SEG_F     = 7'b0111000;

  logic [0:0]           r_state;
  logic [0:0]           w_next_state;
  logic                 w_start;
  logic                 w_step;
  logic                 w_done;

  logic [15:0]          r_bin;
  logic [19:0]          r_work;
  logic [3:0]           r_cnt;
  logic                 r_flag;
  logic                 r_busy;
  logic [19:0]          w_adj;
  logic [35:0]          w_shift;

  logic [SCAN_BITS-1:0] r_scan;
  logic [2:0]           w_sel;
  logic [4:0]           w_nz;
  logic [3:0]           w_digit;
  logic [7:0]           w_an;
  logic [6:0]           w_ssd;

  // Segment pattern for one BCD digit; codes 10..14 never occur and show blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      4'd15:   s = c_SEG_F;
      default: s = c_SEG_BLANK;
    endcase
    return s;
  endfunction

  // FSM state register; reset aborts any conversion in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state: accept Load only from IDLE, return after the 16th step.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (Load)                  w_next_state = S_CONVERT;
      S_CONVERT: if (r_cnt == 4'd15)        w_next_state = S_IDLE;
      default:                              w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: datapath controls decoded from the current state.
  always_comb begin
    w_start = (r_state == S_IDLE) && Load;
    w_step  = (r_state == S_CONVERT);
    w_done  = w_step && (r_cnt == 4'd15);
  end

  // Add-3 correction on every BCD nibble >= 5, then shift {work,bin} left.
  always_comb begin
    w_adj = r_work;
    for (int k = 0; k < 5; k++) begin
      if (r_work[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
    end
    w_shift = {w_adj[18:0], r_bin, 1'b0};
  end

  // Conversion datapath; Busy is registered so it covers edges t+1..t+15 only.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_bin  <= '0;
      r_work <= '0;
      r_cnt  <= '0;
      r_flag <= 1'b0;
      r_busy <= 1'b0;
      BcdOut <= '0;
    end else begin
      r_busy <= w_step && !w_done;
      if (w_start) begin
        r_bin  <= Value;
        r_flag <= Flag;
        r_work <= '0;
        r_cnt  <= '0;
      end else if (w_step) begin
        r_work <= w_shift[35:16];
        r_bin  <= w_shift[15:0];
        r_cnt  <= r_cnt + 4'd1;
        if (w_done) BcdOut <= w_shift[35:16];
      end
    end
  end

  assign Busy = r_busy;
  assign Dp   = 1'b1;

  // Digit slot decode with leading-zero blanking from committed data only.
  always_comb begin
    w_sel   = r_scan[SCAN_BITS-1 -: 3];
    w_nz[4] = |BcdOut[19:16];
    for (int k = 3; k >= 0; k--) begin
      w_nz[k] = w_nz[k+1] | (|BcdOut[4*k +: 4]);
    end
    w_digit = 4'd0;
    w_an    = 8'hFF;
    w_ssd   = c_SEG_BLANK;
    if (w_sel <= 3'd4) begin
      w_digit = BcdOut[4*w_sel +: 4];
      if ((w_sel == 3'd0) || w_nz[w_sel]) begin
        w_an  = ~(8'd1 << w_sel);
        w_ssd = seg7(w_digit);
      end
    end else if ((w_sel == 3'd7) && r_flag) begin
      w_an  = 8'h7F;
      w_ssd = c_SEG_F;
    end
  end

  // Free-running scan counter and registered, glitch-free display drivers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_scan <= '0;
      An     <= 8'hFE;
      Ssd    <= 7'b0000001;
    end else begin
      r_scan <= r_scan + SCAN_BITS'(1);
      An     <= w_an;
      Ssd    <= w_ssd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_result_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_result_display
//  Description : Directed self-checking bench for calc_result_display with a
//                4-bit scan counter (two cycles per digit slot, 16-cycle frame).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_calc_result_display;

  logic        Clk;
  logic        Reset;
  logic [15:0] Value;
  logic        Flag;
  logic        Load;
  logic        Busy;
  logic [19:0] BcdOut;
  logic [7:0]  An;
  logic [6:0]  Ssd;
  logic        Dp;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int edges;

  logic [19:0] exp_bcd;
  logic        exp_flag;

  calc_result_display #(.SCAN_BITS(4)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Value  (Value),
    .Flag   (Flag),
    .Load   (Load),
    .Busy   (Busy),
    .BcdOut (BcdOut),
    .An     (An),
    .Ssd    (Ssd),
    .Dp     (Dp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Edges since reset release, used to predict which slot the display shows.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] t [0:9];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
          7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return t[d];
  endfunction

  task automatic exp_disp(input int sel, input logic [19:0] bcd, input logic f,
                          output logic [7:0] an, output logic [6:0] ssd);
    logic [19:0] upper;
    an  = 8'hFF;
    ssd = 7'h7F;
    if (sel <= 4) begin
      upper = bcd >> (4 * sel);
      if (sel == 0 || upper != 20'd0) begin
        an  = ~(8'd1 << sel);
        ssd = seg(upper[3:0]);
      end
    end else if (sel == 7 && f) begin
      an  = 8'h7F;
      ssd = 7'b0111000;
    end
  endtask

  // Sample one full 16-cycle frame and compare each slot with the model.
  task automatic check_frame(input string tag);
    logic [7:0] ean;
    logic [6:0] essd;
    int sel;
    repeat (16) begin
      @(negedge Clk);
      sel = (edges == 0) ? 0 : ((edges - 1) % 16) / 2;
      exp_disp(sel, exp_bcd, exp_flag, ean, essd);
      chk({tag, "_an"},  32'(An),  32'(ean));
      chk({tag, "_ssd"}, 32'(Ssd), 32'(essd));
      chk({tag, "_dp"},  32'(Dp),  32'd1);
    end
  endtask

  // Pulse Load for one edge; returns at the negedge after the capture edge.
  task automatic load_pulse(input logic [15:0] v, input logic f);
    Value = v;
    Flag  = f;
    Load  = 1'b1;
    @(negedge Clk);
    Load  = 1'b0;
  endtask

  // Follow Busy through a conversion and check the committed result.
  task automatic run_conv(input string tag, input logic [19:0] exp);
    chk({tag, "_busy_t0"}, 32'(Busy), 32'd0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge Clk);
      Value = 16'(i * 977);
      chk({tag, "_busy"}, 32'(Busy), 32'd1);
    end
    @(negedge Clk);
    chk({tag, "_busy_done"}, 32'(Busy), 32'd0);
    chk({tag, "_bcd"}, 32'(BcdOut), 32'(exp));
  endtask

  initial begin
    Reset    = 1'b1;
    Load     = 1'b0;
    Value    = 16'd0;
    Flag     = 1'b0;
    exp_bcd  = 20'h0;
    exp_flag = 1'b0;

    // 1: reset state
    repeat (2) @(negedge Clk);
    chk("rst_an",   32'(An),     32'hFE);
    chk("rst_ssd",  32'(Ssd),    32'b0000001);
    chk("rst_bcd",  32'(BcdOut), 32'h0);
    chk("rst_busy", 32'(Busy),   32'd0);
    chk("rst_dp",   32'(Dp),     32'd1);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("midscan_an",  32'(An),  32'hFE);
    chk("midscan_ssd", 32'(Ssd), 32'b0000001);
    @(negedge Clk);
    Reset = 1'b0;
    check_frame("frame_zero_rst");

    // 2: maximum value
    load_pulse(16'd65535, 1'b0);
    exp_bcd = 20'h65535; exp_flag = 1'b0;
    run_conv("max", exp_bcd);
    @(negedge Clk);
    check_frame("frame_max");

    // 3: small value with overflow flag
    load_pulse(16'd7, 1'b1);
    exp_bcd = 20'h00007; exp_flag = 1'b1;
    run_conv("seven", exp_bcd);
    @(negedge Clk);
    check_frame("frame_seven");

    // 4: second Load during conversion is ignored
    load_pulse(16'd1234, 1'b0);
    exp_bcd = 20'h01234; exp_flag = 1'b0;
    repeat (3) @(negedge Clk);
    load_pulse(16'd9, 1'b1);
    repeat (12) @(negedge Clk);
    chk("ign_busy", 32'(Busy),   32'd0);
    chk("ign_bcd",  32'(BcdOut), 32'h01234);
    repeat (20) @(negedge Clk);
    chk("ign_hold_busy", 32'(Busy),   32'd0);
    chk("ign_hold_bcd",  32'(BcdOut), 32'h01234);
    check_frame("frame_1234");

    // 5: reset in the middle of a conversion, then a clean conversion
    load_pulse(16'd10203, 1'b0);
    repeat (8) @(negedge Clk);
    Reset = 1'b1;
    #1;
    exp_bcd = 20'h0; exp_flag = 1'b0;
    chk("abort_bcd",  32'(BcdOut), 32'h0);
    chk("abort_busy", 32'(Busy),   32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    load_pulse(16'd10203, 1'b0);
    exp_bcd = 20'h10203;
    run_conv("interior", exp_bcd);
    @(negedge Clk);
    check_frame("frame_10203");

    // 6: zero value, flag clear after a flagged result
    load_pulse(16'd7, 1'b1);
    exp_bcd = 20'h00007; exp_flag = 1'b1;
    run_conv("seven2", exp_bcd);
    load_pulse(16'd0, 1'b0);
    exp_bcd = 20'h0; exp_flag = 1'b0;
    run_conv("zero", exp_bcd);
    @(negedge Clk);
    check_frame("frame_zero");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
